seq_row_gen: RTL and testbench

SEQ_ROW_GEN -- requirements
Module: seq_row_gen

---
 rtl/seq_row_gen.sv | 104 ++++++++++
 tb/tb_seq_row_gen.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/seq_row_gen.sv
// Row sequence generator: emits runs of rows produced by an LFSR, rule-90, rule-150
// or rotate-left rule from a persistent state register, one row per accepted transfer.
module seq_row_gen #(
    parameter int              WIDTH = 14,
    parameter logic [WIDTH-1:0] TAPS  = 14'h3802,
    parameter logic [WIDTH-1:0] SEED  = 1,
    parameter int              CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] count,
    input  logic [1:0]       mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    output logic [WIDTH-1:0] row_out,
    output logic             row_valid,
    input  logic             row_ready,
    output logic             busy,
    output logic             done,
    output logic             lockup
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1,
        DONE = 2'd2
    } fsm_t;

    fsm_t             fsm_q, fsm_d;
    logic [WIDTH-1:0] state_q, state_d;
    logic [CNT_W-1:0] remaining_q, remaining_d;
    logic [1:0]       mode_q, mode_d;
    logic             lockup_q, lockup_d;
    logic [WIDTH-1:0] succ;

    // Handshake: a row moves on any cycle with row_valid && row_ready; row_valid
    // never drops while a row is pending and row_out holds until it is taken.
    assign row_out   = state_q;
    assign row_valid = (fsm_q == EMIT);
    assign busy      = (fsm_q != IDLE);
    assign done      = (fsm_q == DONE);
    assign lockup    = lockup_q;

    always_comb begin
        succ = state_q;
        case (mode_q)
            2'd0: succ = (state_q == '0) ? SEED : {state_q[WIDTH-2:0], ^(state_q & TAPS)};
            2'd1: succ = (state_q << 1) ^ (state_q >> 1);
            2'd2: succ = (state_q << 1) ^ state_q ^ (state_q >> 1);
            default: succ = {state_q[WIDTH-2:0], state_q[WIDTH-1]};
        endcase
    end

    always_comb begin
        fsm_d       = fsm_q;
        state_d     = state_q;
        remaining_d = remaining_q;
        mode_d      = mode_q;
        lockup_d    = lockup_q;
        case (fsm_q)
            IDLE: begin
                if (load) begin
                    state_d = load_data;
                end else if (start) begin
                    if (count == '0) begin
                        fsm_d = DONE;
                    end else begin
                        fsm_d       = EMIT;
                        remaining_d = count;
                        mode_d      = mode;
                    end
                end
            end
            EMIT: begin
                if (row_ready) begin
                    state_d     = succ;
                    remaining_d = remaining_q - CNT_W'(1);
                    if (mode_q == 2'd0 && state_q == '0) lockup_d = 1'b1;
                    if (remaining_q == CNT_W'(1)) fsm_d = DONE;
                end
            end
            DONE: fsm_d = IDLE;
            default: fsm_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q       <= IDLE;
            state_q     <= SEED;
            remaining_q <= '0;
            mode_q      <= 2'd0;
            lockup_q    <= 1'b0;
        end else begin
            fsm_q       <= fsm_d;
            state_q     <= state_d;
            remaining_q <= remaining_d;
            mode_q      <= mode_d;
            lockup_q    <= lockup_d;
        end
    end

endmodule

// File: tb/tb_seq_row_gen.sv
// Randomized self-checking bench for seq_row_gen against a per-cell behavioural
// model of the four generator rules and the run/handshake protocol.
module tb_seq_row_gen;

    localparam int W     = 14;
    localparam int CNT_W = 16;
    localparam logic [W-1:0] TAPS = 14'h3802;
    localparam logic [W-1:0] SEED = 14'd1;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [CNT_W-1:0] count;
    logic [1:0]       mode;
    logic             load;
    logic [W-1:0]     load_data;
    logic [W-1:0]     row_out;
    logic             row_valid;
    logic             row_ready;
    logic             busy;
    logic             done;
    logic             lockup;

    int errors = 0;
    int checks = 0;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] m_state;
    logic         m_lock;

    seq_row_gen #(.WIDTH(W), .TAPS(TAPS), .SEED(SEED), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .start(start), .count(count), .mode(mode),
        .load(load), .load_data(load_data), .row_out(row_out),
        .row_valid(row_valid), .row_ready(row_ready), .busy(busy),
        .done(done), .lockup(lockup)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // behavioural model: each cell computed from its neighbours, parity by counting
    function automatic logic [W-1:0] model_next(input logic [W-1:0] s, input int md);
        logic [W-1:0] r;
        int ones;
        logic left, right;
        r = '0;
        if (md == 0) begin
            if (s == '0) return SEED;
            ones = 0;
            for (int i = 0; i < W; i++) if (TAPS[i] && s[i]) ones++;
            r = (s * 2) + (ones % 2);
        end else if (md == 3) begin
            r = (s * 2) + (s >> (W - 1));
        end else begin
            for (int i = 0; i < W; i++) begin
                left  = (i > 0)     ? s[i-1] : 1'b0;
                right = (i < W - 1) ? s[i+1] : 1'b0;
                r[i]  = left ^ right ^ ((md == 2) ? s[i] : 1'b0);
            end
        end
        return r;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m_state = SEED;
        m_lock  = 1'b0;
    endtask

    task automatic do_load(input logic [W-1:0] d);
        load = 1'b1;
        load_data = d;
        tick();
        load = 1'b0;
        m_state = d;
        check("load_row", row_out, d);
    endtask

    // stall: 0 always ready, 1 random ready, 2 ready low 3 cycles after first transfer
    task automatic do_run(input int cnt, input int md, input int stall, input bit noise);
        logic [W-1:0] s;
        int rows, held, guard;
        s = m_state;
        exp_q.delete();
        for (int k = 0; k < cnt; k++) begin
            exp_q.push_back(s);
            if (md == 0 && s == '0) m_lock = 1'b1;
            s = model_next(s, md);
        end
        start = 1'b1;
        count = CNT_W'(cnt);
        mode  = 2'(md);
        tick();
        start = 1'b0;
        count = CNT_W'($urandom_range(0, 20));
        mode  = 2'($urandom_range(0, 3));
        if (cnt == 0) begin
            check("zero_done", done, 1);
            check("zero_valid", row_valid, 0);
            tick();
            check("zero_done_clear", done, 0);
            return;
        end
        rows = 0; held = 0; guard = 0;
        while (rows < cnt && guard < 500) begin
            guard++;
            check("emit_valid", row_valid, 1);
            check("emit_busy", busy, 1);
            case (stall)
                0: row_ready = 1'b1;
                1: row_ready = 1'($urandom_range(0, 1));
                default: begin
                    row_ready = !(rows == 1 && held < 3);
                    if (!row_ready) held++;
                end
            endcase
            if (noise && $urandom_range(0, 3) == 0) begin
                load = 1'b1;
                load_data = W'($urandom);
                start = 1'b1;
            end
            if (row_ready) begin
                check("row", row_out, exp_q.pop_front());
                rows++;
            end else begin
                check("row_hold", row_out, exp_q[0]);
            end
            tick();
            load  = 1'b0;
            start = 1'b0;
        end
        row_ready = 1'b0;
        check("run_rows", rows, cnt);
        m_state = s;
        check("done_pulse", done, 1);
        check("done_valid", row_valid, 0);
        check("end_state", row_out, m_state);
        check("lockup", lockup, m_lock);
        tick();
        check("done_clear", done, 0);
        check("idle_busy", busy, 0);
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; count = '0; mode = '0;
        load = 1'b0; load_data = '0; row_ready = 1'b0;
        m_state = SEED; m_lock = 1'b0;
        repeat (2) tick();

        // reset values
        do_reset();
        check("rst_row", row_out, SEED);
        check("rst_valid", row_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_lockup", lockup, 0);

        // LFSR run of four from reset, back-to-back transfers
        do_run(4, 0, 0, 1'b0);

        // cellular rules from a single set cell
        do_load(W'(16'h0080));
        do_run(3, 1, 0, 1'b0);
        do_load(W'(16'h0080));
        do_run(2, 2, 0, 1'b0);

        // all-zero LFSR recovery, lockup sticky across runs until reset
        do_load('0);
        do_run(2, 0, 0, 1'b0);
        check("lockup_set", lockup, 1);
        do_load('0);
        do_run(3, 1, 0, 1'b0);
        check("lockup_sticky", lockup, 1);
        do_reset();
        check("lockup_rst", lockup, 0);

        // consumer stalls after first transfer
        do_run(3, 0, 2, 1'b0);

        // reset aborts a run mid-way
        do_reset();
        start = 1'b1; count = CNT_W'(10); mode = 2'd0;
        tick();
        start = 1'b0; row_ready = 1'b1;
        repeat (2) tick();
        row_ready = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_valid", row_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_row", row_out, SEED);
        check("abort_done", done, 0);
        tick();
        check("abort_done_later", done, 0);
        m_state = SEED; m_lock = 1'b0;

        // empty run
        do_run(0, 0, 0, 1'b0);

        // load beats start in the same cycle
        load = 1'b1; load_data = W'(16'h1234); start = 1'b1; count = CNT_W'(5);
        tick();
        load = 1'b0; start = 1'b0;
        m_state = W'(16'h1234);
        check("ls_row", row_out, m_state);
        check("ls_busy", busy, 0);
        tick();
        check("ls_valid", row_valid, 0);

        // randomized runs with stalls and ignored load/start noise
        for (int n = 0; n < 25; n++) begin
            if ($urandom_range(0, 3) == 0) do_load(W'($urandom));
            do_run($urandom_range(0, 8), $urandom_range(0, 3), 1, 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
